// File: rtl/dgram_access_if.sv
// dgram_access_if: command, write-payload, read-payload, bus-access and completion
// signals of the datagram access sequencer. The slave modport is the sequencer's view.
interface dgram_access_if;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned LEN_W  = 11;
    localparam int unsigned DATA_W = 8;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_read;

    logic              din_valid;
    logic              din_ready;
    logic [DATA_W-1:0] din_data;

    logic              dout_valid;
    logic              dout_ready;
    logic [DATA_W-1:0] dout_data;

    logic              bus_sof;
    logic              bus_eof;
    logic              bus_valid;
    logic              bus_read;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ready;
    logic [DATA_W-1:0] bus_rdata;

    logic              done;
    logic              done_wkc;
    logic              done_err;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, cmd_read,
        input  din_valid, din_data,
        input  dout_ready,
        input  bus_ready, bus_rdata,
        output cmd_ready, din_ready,
        output dout_valid, dout_data,
        output bus_sof, bus_eof, bus_valid, bus_read, bus_addr, bus_wdata,
        output done, done_wkc, done_err
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_len, cmd_read,
        output din_valid, din_data,
        output dout_ready,
        output bus_ready, bus_rdata,
        input  cmd_ready, din_ready,
        input  dout_valid, dout_data,
        input  bus_sof, bus_eof, bus_valid, bus_read, bus_addr, bus_wdata,
        input  done, done_wkc, done_err
    );
endinterface

// File: rtl/dgram_access.sv
// dgram_access: turns a datagram command (address, length, direction) into a sequence
// of single-byte downstream accesses, streaming write bytes in and read bytes out.
// Bytes above 16'h0FFE are never put on the bus; they complete internally and flag an error.
// Optional feature: define DGRAM_ACCESS_TIMEOUT_EN to abandon a byte after 15 cycles
// without bus_ready; without it the sequencer waits for bus_ready indefinitely.
module dgram_access (
    input  logic          clk,
    input  logic          rst_n,
    dgram_access_if.slave io
);
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned LEN_W  = 11;
    localparam int unsigned DATA_W = 8;
    localparam logic [ADDR_W-1:0] ADDR_MAX = 16'h0FFE;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        REQ   = 3'd2,
        PUSH  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  rem_q;
    logic              rd_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              hit_q;
    logic              err_q;
    logic              alive_q;

    logic in_range_c;
    logic tmo_hit_c;
    logic cmd_fire_c;
    logic din_fire_c;
    logic byte_done_c;
    logic bus_ok_c;
    logic cmd_ready_c;
    logic din_ready_c;
    logic dout_valid_c;
    logic bus_valid_c;
    logic done_c;

    assign in_range_c = (addr_q <= ADDR_MAX);

`ifdef DGRAM_ACCESS_TIMEOUT_EN
    localparam int unsigned TMO_W = 4;
    localparam logic [TMO_W-1:0] TMO_LAST = 4'd14;

    logic [TMO_W-1:0] tmo_q;

    // Cycles spent waiting on the current byte; restarts with every byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else if ((state_q != REQ) || byte_done_c) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end

    assign tmo_hit_c = (tmo_q == TMO_LAST);
`else
    assign tmo_hit_c = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-state handshake strobes
    always_comb begin
        state_d      = state_q;
        cmd_fire_c   = 1'b0;
        din_fire_c   = 1'b0;
        byte_done_c  = 1'b0;
        bus_ok_c     = 1'b0;
        cmd_ready_c  = 1'b0;
        din_ready_c  = 1'b0;
        dout_valid_c = 1'b0;
        bus_valid_c  = 1'b0;
        done_c       = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready_c = alive_q;
                if (alive_q && io.cmd_valid) begin
                    cmd_fire_c = 1'b1;
                    if (io.cmd_len == '0) begin
                        state_d = DONE;
                    end else if (io.cmd_read) begin
                        state_d = REQ;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                din_ready_c = 1'b1;
                if (io.din_valid) begin
                    din_fire_c = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                bus_valid_c = in_range_c;
                bus_ok_c    = in_range_c && io.bus_ready;
                byte_done_c = !in_range_c || io.bus_ready || tmo_hit_c;
                if (byte_done_c) begin
                    if (rd_q) begin
                        state_d = PUSH;
                    end else if (rem_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            PUSH: begin
                dout_valid_c = 1'b1;
                if (io.dout_ready) begin
                    state_d = (rem_q == '0) ? DONE : REQ;
                end
            end
            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datagram context, payload bytes and completion flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_q <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            rd_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            hit_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            if (cmd_fire_c) begin
                addr_q <= io.cmd_addr;
                len_q  <= io.cmd_len;
                rem_q  <= io.cmd_len;
                rd_q   <= io.cmd_read;
                hit_q  <= 1'b0;
                err_q  <= 1'b0;
            end
            if (din_fire_c) begin
                wdata_q <= io.din_data;
            end
            if (byte_done_c) begin
                addr_q  <= addr_q + ADDR_W'(1);
                rem_q   <= rem_q - LEN_W'(1);
                rdata_q <= bus_ok_c ? io.bus_rdata : '0;
                if (bus_ok_c) begin
                    hit_q <= 1'b1;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // Port drive; bus fields read as zero whenever no access is presented
    assign io.cmd_ready  = cmd_ready_c;
    assign io.din_ready  = din_ready_c;
    assign io.dout_valid = dout_valid_c;
    assign io.dout_data  = dout_valid_c ? rdata_q : '0;
    assign io.bus_valid  = bus_valid_c;
    assign io.bus_read   = bus_valid_c & rd_q;
    assign io.bus_addr   = bus_valid_c ? addr_q : '0;
    assign io.bus_wdata  = bus_valid_c ? wdata_q : '0;
    assign io.bus_sof    = bus_valid_c && (rem_q == len_q);
    assign io.bus_eof    = bus_valid_c && (rem_q == LEN_W'(1));
    assign io.done       = done_c;
    assign io.done_wkc   = done_c & hit_q & ~err_q;
    assign io.done_err   = done_c & err_q;
endmodule
